addsub_result_accum: RTL and testbench

//  Downstream stage of the 4-bit two's-complement adder/subtractor. Consumes its signed

---
 rtl/addsub_result_accum.sv | 102 ++++++++++
 tb/tb_addsub_result_accum.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_result_accum.sv
// Accumulates COUNT signed adder results into a saturating ACC_W-bit frame total and
// hands the total downstream over valid/ready; one frame in flight at a time.
module addsub_result_accum #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sat
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);
    localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SUM_MIN = ~SUM_MAX;

    typedef enum logic {ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic signed [ACC_W:0] sum_full;
    logic                  clip_hi, clip_lo;
    logic [ACC_W-1:0]      acc_clamped;
    logic                  accept;

    // One guard bit is enough: |in_data| is always smaller than the accumulator range.
    assign sum_full = $signed({acc_q[ACC_W-1], acc_q})
                    + $signed({{(ACC_W + 1 - DATA_W){in_data[DATA_W-1]}}, in_data});
    assign clip_hi  = sum_full > SUM_MAX;
    assign clip_lo  = sum_full < SUM_MIN;
    assign acc_clamped = clip_hi ? SUM_MAX[ACC_W-1:0] :
                         clip_lo ? SUM_MIN[ACC_W-1:0] : sum_full[ACC_W-1:0];

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = acc_clamped;
                        sat_d = sat_q | clip_hi | clip_lo;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_addsub_result_accum.sv
// Scoreboard bench: dut_a uses default widths, dut_b uses ACC_W=5 for the saturation cases.
module tb_addsub_result_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;

    logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_sat;
    logic [3:0] a_in_data = '0;
    logic [7:0] a_out_sum;

    logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_sat;
    logic [3:0] b_in_data = '0;
    logic [4:0] b_out_sum;

    int checks = 0;
    int errors = 0;

    logic [8:0] qa[$];   // {sat, sum}
    logic [5:0] qb[$];

    always #5 clk = ~clk;

    addsub_result_accum #(.DATA_W(4), .ACC_W(8), .COUNT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_sat(a_out_sat));

    addsub_result_accum #(.DATA_W(4), .ACC_W(5), .COUNT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_sat(b_out_sat));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a frame transfers on out_valid & out_ready unless clear drops it.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready && !clear) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_frame: got sum=%0d sat=%0b expected none", a_out_sum, a_out_sat);
            end else begin
                logic [8:0] e;
                e = qa.pop_front();
                if ({a_out_sat, a_out_sum} !== e) begin
                    errors++;
                    $display("FAIL a_frame: got sat=%0b sum=%0h expected sat=%0b sum=%0h",
                             a_out_sat, a_out_sum, e[8], e[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready && !clear) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_frame: got sum=%0h sat=%0b expected none", b_out_sum, b_out_sat);
            end else begin
                logic [5:0] e;
                e = qb.pop_front();
                if ({b_out_sat, b_out_sum} !== e) begin
                    errors++;
                    $display("FAIL b_frame: got sat=%0b sum=%0h expected sat=%0b sum=%0h",
                             b_out_sat, b_out_sum, e[5], e[4:0]);
                end
            end
        end
    end

    // One clock of stimulus; called and returning at posedge+1.
    task automatic da(input logic v, input logic [3:0] d, input logic rdy, input logic clr);
        a_in_valid = v; a_in_data = d; a_out_ready = rdy; clear = clr;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic db(input logic v, input logic [3:0] d, input logic rdy);
        b_in_valid = v; b_in_data = d; b_out_ready = rdy; clear = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state, checked before any clock edge.
        #3;
        chk("rst_a_in_ready", a_in_ready, 1);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_sum", a_out_sum, 0);
        chk("rst_a_out_sat", a_out_sat, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        chk("rst_b_out_sum", b_out_sum, 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic frame 5 + 2 - 6 + 6 = 7
        qa.push_back({1'b0, 8'd7});
        da(1, 4'd5, 1, 0);
        chk("t1_partial1", a_out_sum, 8'd5);
        da(1, 4'd2, 1, 0);
        da(1, 4'b1010, 1, 0);
        chk("t1_partial3", a_out_sum, 8'd1);
        chk("t1_not_done_yet", a_out_valid, 0);
        da(1, 4'd6, 1, 0);
        chk("t1_out_valid", a_out_valid, 1);
        chk("t1_in_ready_done", a_in_ready, 0);
        chk("t1_out_sum", a_out_sum, 8'd7);
        da(0, 4'd0, 1, 0);
        chk("t1_back_in_ready", a_in_ready, 1);
        chk("t1_back_out_valid", a_out_valid, 0);
        chk("t1_acc_cleared", a_out_sum, 0);

        // 2: positive saturation on ACC_W=5
        qb.push_back({1'b1, 5'd15});
        db(1, 4'd7, 1); chk("t2_sum1", b_out_sum, 5'd7);  chk("t2_sat1", b_out_sat, 0);
        db(1, 4'd7, 1); chk("t2_sum2", b_out_sum, 5'd14); chk("t2_sat2", b_out_sat, 0);
        db(1, 4'd7, 1); chk("t2_sum3", b_out_sum, 5'd15); chk("t2_sat3", b_out_sat, 1);
        db(1, 4'd7, 1); chk("t2_sum4", b_out_sum, 5'd15); chk("t2_valid", b_out_valid, 1);
        db(0, 4'd0, 1);

        // 3: negative saturation then recovery: -8, -16, -16(clip), -13
        qb.push_back({1'b1, 5'b10011});
        db(1, 4'b1000, 1); chk("t3_sum1", b_out_sum, 5'b11000);
        db(1, 4'b1000, 1); chk("t3_sum2", b_out_sum, 5'b10000); chk("t3_sat2", b_out_sat, 0);
        db(1, 4'b1000, 1); chk("t3_sum3", b_out_sum, 5'b10000); chk("t3_sat3", b_out_sat, 1);
        db(1, 4'd3, 1);    chk("t3_sum4", b_out_sum, 5'b10011); chk("t3_sat4", b_out_sat, 1);
        db(0, 4'd0, 1);
        chk("t3_sat_cleared", b_out_sat, 0);

        // 4: output backpressure with input pressure
        qa.push_back({1'b0, 8'd7});
        da(1, 4'd5, 0, 0);
        da(1, 4'd2, 0, 0);
        da(1, 4'b1010, 0, 0);
        da(1, 4'd6, 0, 0);
        for (int i = 0; i < 3; i++) begin
            da(1, 4'd3, 0, 0);
            chk("t4_hold_sum", a_out_sum, 8'd7);
            chk("t4_hold_in_ready", a_in_ready, 0);
            chk("t4_hold_valid", a_out_valid, 1);
        end
        da(1, 4'd3, 1, 0);
        chk("t4_released_sum", a_out_sum, 0);
        chk("t4_released_ready", a_in_ready, 1);
        qa.push_back({1'b0, 8'd12});
        for (int i = 0; i < 4; i++) da(1, 4'd3, 1, 0);
        chk("t4_frame2_sum", a_out_sum, 8'd12);
        da(0, 4'd0, 1, 0);

        // 5: input gaps, valid pattern 1,0,0,1,1,0,1
        qa.push_back({1'b0, 8'd4});
        begin
            logic [6:0] pat;
            pat = 7'b1011001;  // bit 0 first
            for (int i = 0; i < 7; i++) begin
                da(pat[i], 4'd1, 1, 0);
                if (i == 5) chk("t5_gap_hold", a_out_sum, 8'd3);
            end
        end
        chk("t5_valid", a_out_valid, 1);
        chk("t5_sum", a_out_sum, 8'd4);
        da(0, 4'd0, 1, 0);

        // 6a: clear mid-frame, including an accept in the clear cycle
        da(1, 4'd5, 1, 0);
        da(1, 4'd2, 1, 0);
        da(1, 4'd7, 1, 1);
        chk("t6_clear_sum", a_out_sum, 0);
        chk("t6_clear_ready", a_in_ready, 1);
        qa.push_back({1'b0, 8'd4});
        for (int i = 0; i < 4; i++) da(1, 4'd1, 1, 0);
        chk("t6_after_clear_sum", a_out_sum, 8'd4);
        da(0, 4'd0, 1, 0);

        // 6b: clear in DONE beats out_ready; the frame is dropped
        for (int i = 0; i < 4; i++) da(1, 4'd2, 0, 0);
        chk("t6_done_before_clear", a_out_valid, 1);
        da(0, 4'd0, 1, 1);
        chk("t6_clear_done_valid", a_out_valid, 0);
        chk("t6_clear_done_sum", a_out_sum, 0);

        // 6c: async reset mid-frame
        da(1, 4'd5, 1, 0);
        da(1, 4'd2, 1, 0);
        a_in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_sum", a_out_sum, 0);
        chk("t6_rst_ready", a_in_ready, 1);
        chk("t6_rst_valid", a_out_valid, 0);
        chk("t6_rst_sat", a_out_sat, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_post_rst_ready", a_in_ready, 1);
        qa.push_back({1'b0, 8'd4});
        for (int i = 0; i < 4; i++) da(1, 4'd1, 1, 0);
        chk("t6_post_rst_sum", a_out_sum, 8'd4);
        da(0, 4'd0, 1, 0);
        da(0, 4'd0, 1, 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
